// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Imported by the fetch buffer and the fetch_unit top.
package fetch_pkg;

   // Instruction presented on a bubble cycle.
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   // Sequential fetch stride in bytes.
   localparam logic [31:0] PC_INC = 32'd4;

   // One buffered instruction together with the address it was fetched from.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   // Request-side controller states.
   typedef enum logic [1:0] {
      RST,
      FETCH,
      WAIT,
      DRAIN
   } fetch_state_t;

   // Redirect targets are word aligned; the two low bits are dropped.
   function automatic logic [31:0] alignPc(input logic [31:0] addr);
      return addr & ~32'h0000_0003;
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of everything that crosses the fetch-stage boundary: the
// hazard/redirect controls, the instruction-memory request/response
// channel and the IF/ID presentation signals.
// master = the fetch unit, slave = the environment driving it.
interface fetch_unit_if;

   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;

   logic [31:0] pc_out;
   logic [31:0] instruction;
   logic        if_valid;

   modport master (
      input  stall,
      input  branch_taken,
      input  branch_target,
      input  imem_ready,
      input  imem_rvalid,
      input  imem_rdata,
      output imem_req,
      output imem_addr,
      output pc_out,
      output instruction,
      output if_valid
   );

   modport slave (
      output stall,
      output branch_taken,
      output branch_target,
      output imem_ready,
      output imem_rvalid,
      output imem_rdata,
      input  imem_req,
      input  imem_addr,
      input  pc_out,
      input  instruction,
      input  if_valid
   );

endinterface

// File: rtl/fetch_buffer.sv
// Two-entry FIFO holding fetched {pc, instruction} pairs between the
// memory response and the IF/ID presentation. Supports simultaneous
// push and pop, and a synchronous flush used on redirect and reset.
module fetch_buffer
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_flush,
   input  logic         i_push,
   input  fetch_entry_t i_pushEntry,
   input  logic         i_pop,
   output logic [1:0]   o_count,
   output fetch_entry_t o_head
);

   fetch_entry_t r_entries [2];
   logic         r_rdPtr;
   logic         r_wrPtr;
   logic [1:0]   r_count;

   logic         w_doPop;
   logic         w_doPush;

   // A pop only happens when something is held; a push into a full buffer
   // is only taken when the head leaves in the same cycle.
   always_comb begin
      w_doPop  = 1'b0;
      w_doPush = 1'b0;
      if (i_pop && (r_count != 2'd0)) begin
         w_doPop = 1'b1;
      end
      if (i_push && ((r_count != 2'(DEPTH)) || w_doPop)) begin
         w_doPush = 1'b1;
      end
   end

   // Pointer and occupancy bookkeeping; flush and reset both empty the FIFO.
   always_ff @(posedge clk) begin
      if (rst || i_flush) begin
         r_rdPtr <= 1'b0;
         r_wrPtr <= 1'b0;
         r_count <= 2'd0;
      end else begin
         if (w_doPush) begin
            r_wrPtr <= ~r_wrPtr;
         end
         if (w_doPop) begin
            r_rdPtr <= ~r_rdPtr;
         end
         r_count <= r_count + {1'b0, w_doPush} - {1'b0, w_doPop};
      end
   end

   // Entry storage carries no reset; validity is tracked by r_count alone.
   always_ff @(posedge clk) begin
      if (!rst && !i_flush && w_doPush) begin
         r_entries[r_wrPtr] <= i_pushEntry;
      end
   end

   assign o_count = r_count;
   assign o_head  = r_entries[r_rdPtr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the program counter, keeps at most one
// request outstanding to instruction memory, buffers up to two returned
// instructions and presents one {pc, instruction} pair per cycle to IF/ID.
// Redirects flush the buffer and retarget the PC; a response already in
// flight when a redirect hits is drained and thrown away.
// Optional build macro: FETCH_BYPASS_EN -- when the buffer is empty, a
// response returning in WAIT is shown on the outputs in the same cycle
// instead of being pushed into the buffer first.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned BUF_DEPTH = 2
) (
   input  logic          clk,
   input  logic          rst,
   fetch_unit_if.master  bus
);

   fetch_state_t r_state;
   fetch_state_t w_nextState;

   logic [31:0]  r_fetchPc;
   logic [31:0]  r_reqPc;

   logic         w_req;
   logic         w_reqFire;
   logic         w_respAccept;
   logic         w_bypass;
   logic         w_push;
   logic         w_pop;
   logic         w_flush;
   logic [31:0]  w_targetPc;

   logic [1:0]   w_count;
   fetch_entry_t w_head;
   fetch_entry_t w_pushEntry;

   logic [31:0]  w_pcOut;
   logic [31:0]  w_instrOut;
   logic         w_validOut;

   assign w_targetPc  = alignPc(bus.branch_target);
   assign w_reqFire   = w_req && bus.imem_ready;
   assign w_flush     = bus.branch_taken;
   assign w_pushEntry = '{pc: r_reqPc, instr: bus.imem_rdata};

   fetch_buffer #(
      .DEPTH (BUF_DEPTH)
   ) u_buffer (
      .clk         (clk),
      .rst         (rst),
      .i_flush     (w_flush),
      .i_push      (w_push),
      .i_pushEntry (w_pushEntry),
      .i_pop       (w_pop),
      .o_count     (w_count),
      .o_head      (w_head)
   );

   // Controller next-state logic. Only FETCH may raise a request, and only
   // while the buffer has room for the reply, so buffered plus outstanding
   // never exceeds the buffer depth. A redirect while a reply is still owed
   // parks in DRAIN until that stale reply has been swallowed.
   always_comb begin
      w_nextState  = r_state;
      w_req        = 1'b0;
      w_respAccept = 1'b0;
      case (r_state)
         RST: begin
            w_nextState = FETCH;
         end
         FETCH: begin
            w_req = (w_count < 2'(BUF_DEPTH)) && !bus.branch_taken;
            if (w_req && bus.imem_ready) begin
               w_nextState = WAIT;
            end
         end
         WAIT: begin
            if (bus.branch_taken) begin
               w_nextState = bus.imem_rvalid ? FETCH : DRAIN;
            end else if (bus.imem_rvalid) begin
               w_respAccept = 1'b1;
               w_nextState  = FETCH;
            end
         end
         DRAIN: begin
            if (bus.imem_rvalid) begin
               w_nextState = FETCH;
            end
         end
         default: begin
            w_nextState = RST;
         end
      endcase
   end

   // Decide whether a fresh reply goes straight to the outputs or into the
   // buffer. Bypass only applies when nothing older is waiting ahead of it
   // and the consumer will take it this cycle.
   always_comb begin
      w_bypass = 1'b0;
`ifdef FETCH_BYPASS_EN
      w_bypass = w_respAccept && (w_count == 2'd0) && !bus.stall;
`endif
      w_push = w_respAccept && !w_bypass;
   end

   // Presentation to IF/ID: buffer head when available, otherwise the
   // bypassed reply, otherwise a NOP bubble. A redirect always yields a
   // bubble and never consumes the head.
   always_comb begin
      w_pcOut    = 32'h0000_0000;
      w_instrOut = NOP_INSTR;
      w_validOut = 1'b0;
      w_pop      = 1'b0;
      if (!bus.branch_taken) begin
         if (w_count != 2'd0) begin
            w_pcOut    = w_head.pc;
            w_instrOut = w_head.instr;
            w_validOut = 1'b1;
            w_pop      = !bus.stall;
         end else if (w_bypass) begin
            w_pcOut    = r_reqPc;
            w_instrOut = bus.imem_rdata;
            w_validOut = 1'b1;
         end
      end
   end

   // State and program-counter registers. A redirect retargets the PC; an
   // accepted request remembers its own address for the reply and steps
   // the PC by one word, wrapping at the top of the address space.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= RST;
         r_fetchPc <= RESET_PC;
         r_reqPc   <= RESET_PC;
      end else begin
         r_state <= w_nextState;
         if (bus.branch_taken) begin
            r_fetchPc <= w_targetPc;
         end else if (w_reqFire) begin
            r_reqPc   <= r_fetchPc;
            r_fetchPc <= r_fetchPc + PC_INC;
         end
      end
   end

   assign bus.imem_req    = w_req;
   assign bus.imem_addr   = r_fetchPc;
   assign bus.pc_out      = w_pcOut;
   assign bus.instruction = w_instrOut;
   assign bus.if_valid    = w_validOut;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed timing scenarios followed by a randomized
// run. A memory model answers requests, a scoreboard holds the expected
// program-order stream, and a monitor compares every presented instruction.
`timescale 1ns/1ps
module tb_fetch_unit;

   localparam logic [31:0] ResetPc = 32'h0000_0000;
`ifdef FETCH_BYPASS_EN
   localparam int Byp = 1;
`else
   localparam int Byp = 0;
`endif

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } expEntry_t;

   logic clk = 1'b0;
   logic rst;

   fetch_unit_if bus ();

   fetch_unit #(
      .RESET_PC  (ResetPc),
      .BUF_DEPTH (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   int        nChecks   = 0;
   int        nErrors   = 0;
   int        consumed  = 0;
   bit        memRandom = 1'b0;
   int        memK      = 1;
   expEntry_t expQ[$];

   // Memory contents: a fixed scramble of the address, never zero-valued
   // for the small addresses used, so it cannot be confused with a NOP.
   function automatic logic [31:0] memFunc(input logic [31:0] addr);
      return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   // Expected stream after a reset or redirect: straight-line code from
   // the start address, wrapping naturally in 32 bits.
   function automatic void loadExpected(input logic [31:0] base);
      logic [31:0] pc;
      expQ.delete();
      pc = base;
      for (int i = 0; i < 256; i++) begin
         expQ.push_back('{pc: pc, instr: memFunc(pc)});
         pc = pc + 32'd4;
      end
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nErrors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
      end
   endtask

   // Drive one cycle's worth of control inputs just after the rising edge
   // and restart the expected stream on reset or redirect.
   task automatic applyStimulus(input logic rstV, input logic stallV,
                                input logic brV, input logic [31:0] tgtV);
      @(posedge clk);
      #1;
      rst               = rstV;
      bus.stall         = stallV;
      bus.branch_taken  = brV;
      bus.branch_target = tgtV;
      if (rstV) begin
         loadExpected(ResetPc);
      end else if (brV) begin
         loadExpected(tgtV & ~32'h0000_0003);
      end
   endtask

   task automatic step(input logic stallV, input logic brV, input logic [31:0] tgtV);
      applyStimulus(1'b0, stallV, brV, tgtV);
      @(negedge clk);
   endtask

   // Two reset cycles, then release; returns at mid-cycle of the first
   // cycle after release with the reset-value checks done.
   task automatic startAfterReset(input logic stallV);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      step(stallV, 1'b0, 32'h0);
      checkOutput("reset imem_req", 32'(bus.imem_req), 32'h0);
      checkOutput("reset imem_addr", bus.imem_addr, ResetPc);
      checkOutput("reset pc_out", bus.pc_out, 32'h0);
      checkOutput("reset instruction", bus.instruction, 32'h0);
      checkOutput("reset if_valid", 32'(bus.if_valid), 32'h0);
   endtask

   // Instruction memory: one request in flight at most, reply k cycles
   // after acceptance, cancelled by reset. Flags a second acceptance while
   // a reply is still owed.
   initial begin : memModel
      logic        accept;
      logic        respond;
      logic        rstNow;
      logic        pending;
      logic [31:0] acceptAddr;
      logic [31:0] pendAddr;
      int          left;
      pending          = 1'b0;
      pendAddr         = 32'h0;
      left             = 0;
      bus.imem_ready   = 1'b0;
      bus.imem_rvalid  = 1'b0;
      bus.imem_rdata   = 32'h0;
      forever begin
         @(negedge clk);
         accept     = bus.imem_req && bus.imem_ready;
         acceptAddr = bus.imem_addr;
         respond    = bus.imem_rvalid;
         rstNow     = rst;
         @(posedge clk);
         #1;
         if (rstNow) begin
            pending = 1'b0;
         end else begin
            if (respond) begin
               pending = 1'b0;
            end
            if (accept) begin
               checkOutput("single outstanding", 32'(pending), 32'h0);
               pending  = 1'b1;
               pendAddr = acceptAddr;
               left     = memRandom ? int'($urandom_range(1, 3)) : memK;
            end
         end
         bus.imem_rvalid = 1'b0;
         bus.imem_rdata  = $urandom;
         if (pending) begin
            left--;
            if (left == 0) begin
               bus.imem_rvalid = 1'b1;
               bus.imem_rdata  = memFunc(pendAddr);
            end
         end
         bus.imem_ready = memRandom ? ($urandom_range(0, 9) < 7) : 1'b1;
      end
   end

   // Monitor: every presented instruction must be the next one in program
   // order; it is consumed only when the stage is neither stalled nor
   // redirected. Bubbles must read as pc 0 / NOP.
   initial begin : monitor
      expEntry_t e;
      forever begin
         @(negedge clk);
         if (rst === 1'b0) begin
            if (bus.branch_taken) begin
               checkOutput("valid during redirect", 32'(bus.if_valid), 32'h0);
            end
            if (bus.if_valid === 1'b1) begin
               if (expQ.size() == 0) begin
                  nChecks++;
                  nErrors++;
                  $display("[TB] FAIL scoreboard underflow: got pc 0x%08h, expected no output at %0t", bus.pc_out, $time);
               end else begin
                  e = expQ[0];
                  checkOutput("pc_out", bus.pc_out, e.pc);
                  checkOutput("instruction", bus.instruction, e.instr);
                  if (!bus.stall && !bus.branch_taken) begin
                     void'(expQ.pop_front());
                     consumed++;
                  end
               end
            end else begin
               checkOutput("bubble pc_out", bus.pc_out, 32'h0);
               checkOutput("bubble instruction", bus.instruction, 32'h0);
            end
         end
      end
   end

   // Hard stop in case the design wedges the bench.
   initial begin : watchdog
      #500000;
      $display("[TB] FAIL timeout: got no finish, expected finish before 500000 ns");
      $fatal(1, "[TB] timeout");
   end

   // Directed scenarios, then the randomized run, then the summary.
   initial begin : stimulus
      int startConsumed;
      int r;
      logic [31:0] tgt;
      rst               = 1'b1;
      bus.stall         = 1'b0;
      bus.branch_taken  = 1'b0;
      bus.branch_target = 32'h0;
      loadExpected(ResetPc);

      $display("[TB] streaming with ready=1, k=1");
      memRandom = 1'b0;
      memK      = 1;
      startAfterReset(1'b0);
      for (int c = 1; c <= 9; c++) begin
         step(1'b0, 1'b0, 32'h0);
         checkOutput("stream imem_req", 32'(bus.imem_req), 32'(c % 2));
         if ((c % 2) == 1) begin
            checkOutput("stream imem_addr", bus.imem_addr, 32'(4 * ((c - 1) / 2)));
         end
         if (Byp == 1) begin
            checkOutput("stream if_valid", 32'(bus.if_valid), 32'((c >= 2) && ((c % 2) == 0)));
         end else begin
            checkOutput("stream if_valid", 32'(bus.if_valid), 32'((c >= 3) && ((c % 2) == 1)));
         end
      end

      $display("[TB] stall fills the buffer");
      startAfterReset(1'b1);
      for (int c = 1; c <= 7; c++) begin
         step(1'b1, 1'b0, 32'h0);
         if (c == 3) begin
            checkOutput("stall second request", 32'(bus.imem_req), 32'h1);
            checkOutput("stall second addr", bus.imem_addr, 32'h4);
         end
         if (c >= 5) begin
            checkOutput("stall full no request", 32'(bus.imem_req), 32'h0);
            checkOutput("stall held pc", bus.pc_out, 32'h0);
            checkOutput("stall held valid", 32'(bus.if_valid), 32'h1);
         end
      end
      step(1'b0, 1'b0, 32'h0);
      checkOutput("unstall pc first", bus.pc_out, 32'h0);
      checkOutput("unstall still full", 32'(bus.imem_req), 32'h0);
      step(1'b0, 1'b0, 32'h0);
      checkOutput("unstall pc second", bus.pc_out, 32'h4);
      checkOutput("unstall request", 32'(bus.imem_req), 32'h1);
      checkOutput("unstall addr", bus.imem_addr, 32'h8);

      $display("[TB] redirect in WAIT with late response");
      memK = 3;
      startAfterReset(1'b0);
      step(1'b0, 1'b0, 32'h0);
      checkOutput("redir first addr", bus.imem_addr, 32'h0);
      step(1'b0, 1'b1, 32'h0000_0103);
      checkOutput("redir req blocked", 32'(bus.imem_req), 32'h0);
      step(1'b0, 1'b0, 32'h0);
      checkOutput("drain no request", 32'(bus.imem_req), 32'h0);
      step(1'b0, 1'b0, 32'h0);
      checkOutput("drain on stale reply", 32'(bus.imem_req), 32'h0);
      memK = 1;
      step(1'b0, 1'b0, 32'h0);
      checkOutput("redir target req", 32'(bus.imem_req), 32'h1);
      checkOutput("redir target addr", bus.imem_addr, 32'h0000_0100);
      for (int c = 6; c <= 7; c++) begin
         step(1'b0, 1'b0, 32'h0);
         if (c == 7 - Byp) begin
            checkOutput("redir first valid", 32'(bus.if_valid), 32'h1);
            checkOutput("redir first pc", bus.pc_out, 32'h0000_0100);
         end
      end

      $display("[TB] redirect coincident with response");
      memK = 1;
      startAfterReset(1'b0);
      step(1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b1, 32'h0000_0200);
      checkOutput("coincident bubble", 32'(bus.if_valid), 32'h0);
      step(1'b0, 1'b0, 32'h0);
      checkOutput("coincident req", 32'(bus.imem_req), 32'h1);
      checkOutput("coincident addr", bus.imem_addr, 32'h0000_0200);
      checkOutput("coincident dropped", 32'(bus.if_valid), 32'h0);

      $display("[TB] address wrap");
      startAfterReset(1'b0);
      step(1'b0, 1'b1, 32'hFFFF_FFFC);
      checkOutput("wrap redirect no req", 32'(bus.imem_req), 32'h0);
      step(1'b0, 1'b0, 32'h0);
      checkOutput("wrap top addr", bus.imem_addr, 32'hFFFF_FFFC);
      for (int c = 3; c <= 4; c++) begin
         step(1'b0, 1'b0, 32'h0);
         if (c == 4 - Byp) begin
            checkOutput("wrap top pc", bus.pc_out, 32'hFFFF_FFFC);
         end
      end
      checkOutput("wrap next req", 32'(bus.imem_req), 32'h1);
      checkOutput("wrap next addr", bus.imem_addr, 32'h0);

      $display("[TB] reset while waiting");
      memK = 1;
      startAfterReset(1'b1);
      step(1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b0, 32'h0);
      memK = 3;
      step(1'b1, 1'b0, 32'h0);
      checkOutput("pre-reset req", 32'(bus.imem_req), 32'h1);
      step(1'b1, 1'b0, 32'h0);
      checkOutput("pre-reset valid", 32'(bus.if_valid), 32'h1);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      memK = 1;
      step(1'b0, 1'b0, 32'h0);
      checkOutput("mid reset imem_req", 32'(bus.imem_req), 32'h0);
      checkOutput("mid reset imem_addr", bus.imem_addr, ResetPc);
      checkOutput("mid reset pc_out", bus.pc_out, 32'h0);
      checkOutput("mid reset instruction", bus.instruction, 32'h0);
      checkOutput("mid reset if_valid", 32'(bus.if_valid), 32'h0);
      step(1'b0, 1'b0, 32'h0);
      checkOutput("restart req", 32'(bus.imem_req), 32'h1);
      checkOutput("restart addr", bus.imem_addr, ResetPc);
      for (int c = 0; c < 4; c++) begin
         step(1'b0, 1'b0, 32'h0);
      end

      $display("[TB] randomized run");
      memRandom     = 1'b1;
      startConsumed = consumed;
      for (int c = 0; c < 3000; c++) begin
         r = int'($urandom_range(0, 99));
         if (r < 1) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
         end else if (r < 5) begin
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            applyStimulus(1'b0, 1'b0, 1'b1, tgt);
         end else begin
            applyStimulus(1'b0, ($urandom_range(0, 9) < 3), 1'b0, 32'h0);
         end
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      checkOutput("random progress", 32'((consumed - startConsumed) >= 200), 32'h1);

      $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage. Owns the program counter, issues single-outstanding requests to instruction memory, buffers up to two returned instructions, and presents one {pc, instruction} pair per cycle to the IF/ID pipeline register via `pc_out`/`instruction`. Handles decode/hazard stalls and branch redirects, and inserts NOP bubbles when no instruction is available.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `BUF_DEPTH`, 2, instruction buffer entries (fixed at 2; any other value is illegal)
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `stall`  in  1  hold current output, no pop (from hazard unit)
- `branch_taken`  in  1  redirect pulse; priority over `stall`
- `branch_target`  in  32  redirect address; bits [1:0] ignored (forced 00)
- `imem_req`  out  1  request valid
- `imem_addr`  out  32  request address (= fetch_pc)
- `imem_ready`  in  1  memory accepts request this cycle
- `imem_rvalid`  in  1  response valid
- `imem_rdata`  in  32  response instruction
- `pc_out`  out  32  pc of presented instruction
- `instruction`  out  32  presented instruction, NOP (32'h0) when none
- `if_valid`  out  1  1 = real instruction presented, 0 = bubble

## Operation
- FSM states: RST, FETCH, WAIT, DRAIN.
- RST: one cycle after `rst` deasserts; `imem_req`=0, `imem_rvalid` ignored; next state FETCH.
- FETCH: `imem_req`=1 iff (buf_count + 0 outstanding) < 2 and `branch_taken`=0. On `imem_req && imem_ready`: latch request pc, fetch_pc += 4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), go WAIT.
- WAIT: `imem_req`=0. On `imem_rvalid`: push {request pc, `imem_rdata`}, go FETCH. Occupancy rule buf_count + outstanding ≤ 2 guarantees no push when full.
- DRAIN: `imem_req`=0; the next `imem_rvalid` is discarded, then go FETCH.
- Output: buffer non-empty → `pc_out`/`instruction` = head, `if_valid`=1; empty → `pc_out`=0, `instruction`=NOP, `if_valid`=0. Pop head when non-empty, `stall`=0, `branch_taken`=0. Same-cycle push and pop allowed.
- Redirect (`branch_taken`=1): outputs forced to NOP/`if_valid`=0 this cycle, no pop; buffer flushed; fetch_pc ← {`branch_target`[31:2], 2'b00}. From WAIT without `imem_rvalid` → DRAIN; from WAIT with `imem_rvalid` the response is discarded → FETCH; from FETCH/DRAIN → FETCH (DRAIN stays DRAIN if its response has not yet arrived). Any request accepted in the same cycle is impossible (`imem_req`=0 under redirect).
- Reset mid-operation: instruction memory shares `rst`; in-flight responses are cancelled. State → RST, buffer empty, fetch_pc ← `RESET_PC`.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=`RESET_PC`, `pc_out`=0, `instruction`=32'h0, `if_valid`=0.
- Request accepted cycle t, `imem_rvalid` at t+k (k ≥ 1); entry visible on outputs at t+k+1.
- Sustained throughput: one instruction every 2 cycles with k=1 (single outstanding).
- First request after reset: issued in the 2nd cycle after `rst` deasserts.
- Redirect at cycle r: first request to target issued at r+1 (from FETCH) or the cycle after the drained response.

## Configuration
- `FETCH_BYPASS_EN` defined: when buffer empty, `imem_rvalid`=1, `stall`=0, `branch_taken`=0, `imem_rdata` and request pc drive outputs combinationally in cycle t+k with `if_valid`=1, and no push occurs.
- Undefined: no bypass; all responses go through the buffer (latency above).

## Structure
- Package `fetch_pkg`: `NOP_INSTR` (32'h0), `PC_INC` (4), `fetch_entry_t` struct {pc[31:0], instr[31:0]}, `fetch_state_t` enum {RST, FETCH, WAIT, DRAIN}.
- Sub-module `fetch_buffer`: 2-entry FIFO of `fetch_entry_t` with push, pop, synchronous flush, count, head outputs.

## Test plan
- Reset, `imem_ready`=1, k=1 → `imem_addr` 0x0, 0x4, 0x8…; `if_valid` pattern 0,1 alternating; `instruction` equals memory contents in order.
- `stall` held 3 cycles with buffer holding 0x4/0x8 → outputs stay pc 0x4 for 3 cycles, then 0x4, 0x8 in order; no request while count+outstanding=2.
- `branch_taken` with target 0x103 while in WAIT, response arrives 2 cycles later → response discarded, next `imem_addr`=0x100, first output pc 0x100.
- `branch_taken` coincident with `imem_rvalid` → response dropped, no DRAIN, next cycle `imem_addr`=target.
- fetch_pc 0xFFFF_FFFC → next request address 0x0000_0000.
- `rst` asserted in WAIT → next cycle all outputs at reset values, then fetch restarts at `RESET_PC`; with `FETCH_BYPASS_EN`, k=1 empty-buffer response appears on outputs same cycle as `imem_rvalid`.
